// File: rtl/ok_axil_pkg.sv
// ok_axil_pkg: shared types and helpers for the FrontPanel AXI4-Lite register bank.
// Holds response codes, the default bank size, FSM state types and the byte-lane merge.
package ok_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int OK_NUM_REGS = 16;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ok_axil_reg_bank.sv
// ok_axil_reg_bank: AXI4-Lite slave exposing NUM_REGS RW control and RO status words.
// Ports: okClkIn/reset, AXI-Lite AW/W/B/AR/R, ctrl_regs out, status_in in, wr_pulse out.
module ok_axil_reg_bank
  import ok_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = OK_NUM_REGS,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                           okClkIn,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IW = ADDR_WIDTH - 2;

  typedef logic [IW-1:0] idx_t;
  typedef logic [NUM_REGS-1:0][31:0] bank_t;

  w_state_e            w_state, w_state_d;
  logic                aw_held, aw_held_d;
  logic                w_held, w_held_d;
  idx_t                aw_idx, aw_idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  bank_t               ctrl_q, ctrl_d;
  bank_t               status_w;

  r_state_e            r_state, r_state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs, w_hs, ar_hs;
  idx_t                cm_idx, ar_idx;
  logic [31:0]         cm_data;
  logic [3:0]          cm_strb;

  logic                unused_addr_lsbs;

  assign unused_addr_lsbs =
    ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign status_w  = status_in;
  assign ctrl_regs = ctrl_q;
  assign wr_pulse  = pulse_q;

  // Readies are gated by reset so nothing is accepted while it is held.
  assign s_axi_awready =
    !reset && (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready =
    !reset && (w_state == W_IDLE) && !w_held;
  assign s_axi_arready =
    !reset && (r_state == R_IDLE);

  assign s_axi_bvalid = (w_state == W_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (r_state == R_DATA);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // A beat arriving in the commit cycle is used directly.
  assign cm_idx  = aw_held ? aw_idx
                           : s_axi_awaddr[ADDR_WIDTH-1:2];
  assign cm_data = w_held ? wdata_q : s_axi_wdata;
  assign cm_strb = w_held ? wstrb_q : s_axi_wstrb;
  assign ar_idx  = s_axi_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    w_state_d = w_state;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    aw_idx_d  = aw_idx;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    pulse_d   = '0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
          bresp_d   = RESP_DECERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cm_idx == idx_t'(i)) begin
              ctrl_d[i] =
                byte_merge(ctrl_q[i], cm_data, cm_strb);
              pulse_d[i] = 1'b1;
              bresp_d    = RESP_OKAY;
            end
            if (cm_idx == idx_t'(NUM_REGS + i)) begin
              bresp_d = RESP_SLVERR;
            end
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
    endcase
  end

  // Reads sample ctrl_q before this cycle's commit lands.
  always_comb begin
    r_state_d = r_state;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_DECERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == idx_t'(i)) begin
              rdata_d = ctrl_q[i];
              rresp_d = RESP_OKAY;
            end
            if (ar_idx == idx_t'(NUM_REGS + i)) begin
              rdata_d = status_w[i];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      R_DATA: begin
        if (s_axi_rready) r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge okClkIn) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
      pulse_q <= '0;
      ctrl_q  <= {NUM_REGS{RESET_VALUE}};
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      w_state <= w_state_d;
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
      aw_idx  <= aw_idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      pulse_q <= pulse_d;
      ctrl_q  <= ctrl_d;
      r_state <= r_state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule

// File: tb/tb_ok_axil_reg_bank.sv
// tb_ok_axil_reg_bank: directed and random traffic for ok_axil_reg_bank.
// A transaction-level model is compared against the DUT every cycle.
module tb_ok_axil_reg_bank;
  import ok_axil_pkg::*;

  localparam int AW = 12;
  localparam int N  = 16;

  logic              okClkIn = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [AW-1:0]     s_axi_araddr = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;
  logic [N*32-1:0]   ctrl_regs;
  logic [N*32-1:0]   status_in = '0;
  logic [N-1:0]      wr_pulse;

  always #5 okClkIn = ~okClkIn;

  ok_axil_reg_bank dut (
    .okClkIn      (okClkIn),
    .reset        (reset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .ctrl_regs    (ctrl_regs),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic chk_bank(input string nm,
                          input logic [N*32-1:0] exp);
    n_chk++;
    if (ctrl_regs === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, ctrl_regs, exp);
  endtask

  task automatic tick();
    @(posedge okClkIn);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctrl [N];
  bit          m_aw_have, m_w_have, m_bpend, m_rpend;
  int          m_aw_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [N-1:0] m_pulse;
  bit          mdl_ok = 1'b0;

  function automatic logic [1:0] exp_resp(int idx);
    if (idx < N) return RESP_OKAY;
    if (idx < 2*N) return RESP_SLVERR;
    return RESP_DECERR;
  endfunction

  always @(posedge okClkIn) begin
    bit aw_acc, w_acc, ar_acc;
    int ri;
    if (reset) begin
      m_aw_have = 0; m_w_have = 0;
      m_bpend = 0; m_rpend = 0;
      m_pulse = '0;
      for (int i = 0; i < N; i++) m_ctrl[i] = 32'h0;
      mdl_ok = 1'b1;
    end else begin
      aw_acc = s_axi_awvalid && !m_bpend && !m_aw_have;
      w_acc  = s_axi_wvalid && !m_bpend && !m_w_have;
      ar_acc = s_axi_arvalid && !m_rpend;
      m_pulse = '0;
      if (ar_acc) begin
        ri = int'(s_axi_araddr >> 2);
        m_rpend = 1;
        m_rresp = (ri < 2*N) ? RESP_OKAY : RESP_DECERR;
        if (ri < N) m_rdata = m_ctrl[ri];
        else if (ri < 2*N) m_rdata = status_in[32*(ri-N) +: 32];
        else m_rdata = 32'h0;
      end else if (m_rpend && s_axi_rready) begin
        m_rpend = 0;
      end
      if (m_bpend) begin
        if (s_axi_bready) m_bpend = 0;
      end else begin
        if (aw_acc) begin
          m_aw_have = 1;
          m_aw_idx = int'(s_axi_awaddr >> 2);
        end
        if (w_acc) begin
          m_w_have = 1;
          m_wd = s_axi_wdata;
          m_ws = s_axi_wstrb;
        end
        if (m_aw_have && m_w_have) begin
          m_aw_have = 0; m_w_have = 0;
          m_bpend = 1;
          m_bresp = exp_resp(m_aw_idx);
          if (m_aw_idx < N) begin
            for (int b = 0; b < 4; b++)
              if (m_ws[b])
                m_ctrl[m_aw_idx][8*b +: 8] = m_wd[8*b +: 8];
            m_pulse[m_aw_idx] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge okClkIn) begin
    logic [N*32-1:0] ev;
    if (mdl_ok) begin
      chk("awready", s_axi_awready,
          !reset && !m_bpend && !m_aw_have);
      chk("wready", s_axi_wready,
          !reset && !m_bpend && !m_w_have);
      chk("arready", s_axi_arready, !reset && !m_rpend);
      chk("bvalid", s_axi_bvalid, m_bpend);
      if (m_bpend) chk("bresp", s_axi_bresp, m_bresp);
      chk("rvalid", s_axi_rvalid, m_rpend);
      if (m_rpend) begin
        chk("rdata", s_axi_rdata, m_rdata);
        chk("rresp", s_axi_rresp, m_rresp);
      end
      chk("wr_pulse", wr_pulse, m_pulse);
      for (int i = 0; i < N; i++) ev[32*i +: 32] = m_ctrl[i];
      chk_bank("ctrl_regs", ev);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wr(input logic [AW-1:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s,
                    output logic [1:0] resp,
                    output logic [N-1:0] pulse);
    bit done = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1;
    resp = 2'b01; pulse = '0;
    for (int c = 0; c < 50 && !done; c++) begin
      bit ah, wh;
      @(negedge okClkIn);
      ah = s_axi_awvalid && s_axi_awready;
      wh = s_axi_wvalid && s_axi_wready;
      if (s_axi_bvalid && s_axi_bready) begin
        done = 1; resp = s_axi_bresp; pulse = wr_pulse;
      end
      tick();
      if (ah) s_axi_awvalid = 0;
      if (wh) s_axi_wvalid = 0;
    end
    if (!done) chk("wr_timeout", 0, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    output logic [31:0] d,
                    output logic [1:0] r);
    bit done = 0;
    s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 1;
    d = '0; r = 2'b01;
    for (int c = 0; c < 50 && !done; c++) begin
      bit ah;
      @(negedge okClkIn);
      ah = s_axi_arvalid && s_axi_arready;
      if (s_axi_rvalid && s_axi_rready) begin
        done = 1; d = s_axi_rdata; r = s_axi_rresp;
      end
      tick();
      if (ah) s_axi_arvalid = 0;
    end
    if (!done) chk("rd_timeout", 0, 1);
  endtask

  // ---------------- random drivers ----------------
  localparam int NT = 60;
  bit rnd_stop = 0;

  function automatic logic [AW-1:0] rand_addr();
    int sel;
    logic [9:0] idx;
    logic [1:0] lo;
    sel = $urandom_range(0, 9);
    if (sel < 6) idx = 10'($urandom_range(0, N-1));
    else if (sel < 8) idx = 10'($urandom_range(N, 2*N-1));
    else idx = 10'($urandom_range(2*N, 1023));
    lo = 2'($urandom);
    return {idx, lo};
  endfunction

  task automatic aw_drv();
    for (int k = 0; k < NT; k++) begin
      bit hs = 0;
      repeat ($urandom_range(0, 2)) tick();
      s_axi_awaddr = rand_addr(); s_axi_awvalid = 1;
      for (int c = 0; c < 100 && !hs; c++) begin
        @(negedge okClkIn);
        hs = s_axi_awvalid && s_axi_awready;
        tick();
      end
      s_axi_awvalid = 0;
      if (!hs) chk("aw_timeout", 0, 1);
    end
  endtask

  task automatic w_drv();
    for (int k = 0; k < NT; k++) begin
      bit hs = 0;
      repeat ($urandom_range(0, 2)) tick();
      s_axi_wdata = $urandom;
      s_axi_wstrb = 4'($urandom);
      s_axi_wvalid = 1;
      for (int c = 0; c < 100 && !hs; c++) begin
        @(negedge okClkIn);
        hs = s_axi_wvalid && s_axi_wready;
        tick();
      end
      s_axi_wvalid = 0;
      if (!hs) chk("w_timeout", 0, 1);
    end
  endtask

  task automatic ar_drv();
    for (int k = 0; k < NT; k++) begin
      bit hs = 0;
      repeat ($urandom_range(0, 2)) tick();
      s_axi_araddr = rand_addr(); s_axi_arvalid = 1;
      for (int c = 0; c < 100 && !hs; c++) begin
        @(negedge okClkIn);
        hs = s_axi_arvalid && s_axi_arready;
        tick();
      end
      s_axi_arvalid = 0;
      if (!hs) chk("ar_timeout", 0, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0]   resp, rr;
    logic [N-1:0] pulse;
    logic [31:0]  d;
    bit           seen, ah, wh;

    repeat (3) tick();
    @(negedge okClkIn);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_pulse", wr_pulse, 0);
    chk_bank("rst_ctrl", '0);
    tick();
    reset = 0;
    @(negedge okClkIn);
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_wready", s_axi_wready, 1);
    chk("post_rst_arready", s_axi_arready, 1);
    tick();

    wr(12'h004, 32'hDEADBEEF, 4'hF, resp, pulse);
    chk("t1_bresp", resp, RESP_OKAY);
    chk("t1_pulse", pulse, 16'h0002);
    chk("t1_word1", ctrl_regs[63:32], 32'hDEADBEEF);
    @(negedge okClkIn);
    chk("t1_pulse_gone", wr_pulse, 0);
    tick();
    rd(12'h004, d, rr);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", rr, RESP_OKAY);

    wr(12'h008, 32'hAABBCCDD, 4'hF, resp, pulse);
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'h3;
    s_axi_wvalid = 1; s_axi_bready = 1;
    @(negedge okClkIn);
    chk("t2_w_first", s_axi_wready, 1);
    tick();
    s_axi_wvalid = 0;
    tick(); tick();
    s_axi_awaddr = 12'h008; s_axi_awvalid = 1;
    @(negedge okClkIn);
    tick();
    s_axi_awvalid = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge okClkIn);
      seen = s_axi_bvalid;
      tick();
    end
    chk("t2_bseen", seen, 1);
    chk("t2_word2", ctrl_regs[95:64], 32'hAABB3344);

    status_in[31:0] = 32'h12345678;
    rd(12'h040, d, rr);
    chk("t3_rdata", d, 32'h12345678);
    chk("t3_rresp", rr, RESP_OKAY);
    wr(12'h040, 32'hFFFFFFFF, 4'hF, resp, pulse);
    chk("t3_bresp", resp, RESP_SLVERR);
    chk("t3_pulse", pulse, 0);
    chk("t3_word0", ctrl_regs[31:0], 32'h0);
    chk("t3_word1", ctrl_regs[63:32], 32'hDEADBEEF);

    rd(12'h100, d, rr);
    chk("t4_rdata", d, 32'h0);
    chk("t4_rresp", rr, RESP_DECERR);
    wr(12'h100, 32'h01020304, 4'hF, resp, pulse);
    chk("t4_bresp", resp, RESP_DECERR);
    chk("t4_pulse", pulse, 0);

    s_axi_araddr = 12'h004; s_axi_arvalid = 1; s_axi_rready = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge okClkIn);
      seen = s_axi_arvalid && s_axi_arready;
      tick();
    end
    s_axi_arvalid = 0;
    chk("t5_ar_hs", seen, 1);
    fork
      begin
        logic [1:0] r5;
        logic [N-1:0] p5;
        wr(12'h00C, 32'h0BADF00D, 4'hF, r5, p5);
        chk("t5_bresp", r5, RESP_OKAY);
        chk("t5_pulse", p5, 16'h0008);
      end
      begin
        repeat (5) begin
          @(negedge okClkIn);
          chk("t5_rvalid_hold", s_axi_rvalid, 1);
          chk("t5_rdata_hold", s_axi_rdata, 32'hDEADBEEF);
          tick();
        end
      end
    join
    s_axi_rready = 1;
    @(negedge okClkIn);
    chk("t5_rvalid_end", s_axi_rvalid, 1);
    tick();
    s_axi_rready = 0;
    chk("t5_word3", ctrl_regs[127:96], 32'h0BADF00D);

    fork
      begin
        logic [1:0] r6;
        logic [N-1:0] p6;
        wr(12'h004, 32'h55AA55AA, 4'hF, r6, p6);
      end
      rd(12'h004, d, rr);
    join
    chk("t6_pre_write", d, 32'hDEADBEEF);
    chk("t6_word1", ctrl_regs[63:32], 32'h55AA55AA);

    s_axi_awaddr = 12'h010; s_axi_wdata = 32'hCAFEF00D;
    s_axi_wstrb = 4'hF; s_axi_bready = 0;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge okClkIn);
      ah = s_axi_awvalid && s_axi_awready;
      wh = s_axi_wvalid && s_axi_wready;
      seen = s_axi_bvalid;
      tick();
      if (ah) s_axi_awvalid = 0;
      if (wh) s_axi_wvalid = 0;
    end
    chk("t7_bseen", seen, 1);
    reset = 1;
    @(negedge okClkIn);
    tick();
    @(negedge okClkIn);
    chk("t7_bvalid_drop", s_axi_bvalid, 0);
    chk_bank("t7_ctrl_reset", '0);
    tick();
    reset = 0;
    @(negedge okClkIn);
    chk("t7_awready", s_axi_awready, 1);
    chk("t7_wready", s_axi_wready, 1);
    chk("t7_arready", s_axi_arready, 1);
    tick();

    fork
      begin
        fork
          aw_drv();
          w_drv();
          ar_drv();
        join
        rnd_stop = 1;
      end
      begin
        while (!rnd_stop) begin
          s_axi_bready = 1'($urandom);
          s_axi_rready = 1'($urandom);
          for (int i = 0; i < N; i++)
            status_in[32*i +: 32] = $urandom;
          tick();
        end
      end
    join
    s_axi_bready = 1; s_axi_rready = 1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
